rr_encoder_arbiter: RTL and testbench
=====================================

Name: rr_encoder_arbiter

Overview:
Round-robin arbiter that shares one downstream resource among 4 requesters. Its index output uses the same 4-to-2 one-hot encoding as our binary encoder: one-hot 0001/0010/0100/1000 maps to 0/1/2/3. The grant is locked while the winner holds its request. An optional hold timeout forces a release when other requesters are waiting. The block sits between requester agents and the shared datapath, which is steered by grant_idx.

Parameters:
N_REQ, 4, number of requesters (fixed at 4 in this revision)
IDX_W, 2, width of encoded grant index
MAX_HOLD, 16, max consecutive GRANT cycles before forced release when others wait; 0 disables the timeout

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  4  request lines, level-sensitive, bit i = requester i
grant  output  4  one-hot grant (registered), 0000 when idle
grant_idx  output  2  binary index of the granted requester, 0 when idle
grant_valid  output  1  high while any grant bit is set
timeout  output  1  one-cycle pulse on a forced release
hold_cnt  output  8  cycles the current grant has been held (debug)

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant): state=IDLE, grant=0000, grant_idx=0, grant_valid=0, timeout=0, hold_cnt=0, ptr=0.
- Internal ptr[1:0] holds the highest-priority requester for the next arbitration.
- State IDLE:
  - If req != 0 at a clk edge, the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At that edge: grant=onehot(winner), grant_idx=winner, grant_valid=1, hold_cnt=0, ptr=(winner+1) mod 4, state goes to GRANT.
  - Latency: req sampled at edge k, grant visible immediately after edge k (1 cycle).
  - If req == 0: remain in IDLE with all outputs at their idle values.
- State GRANT:
  - Normal release: if req[winner]==0 at an edge, then grant=0000, grant_idx=0, grant_valid=0, state goes to IDLE.
  - Forced release: if req[winner]==1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~grant)!=0, then release as above and timeout=1 for exactly that cycle.
  - Otherwise stay in GRANT with hold_cnt+1. hold_cnt saturates at 255.
- Dead cycle: every release returns to IDLE for at least one cycle. Two grants are therefore never back-to-back; there is always one cycle with grant_valid=0 between them.
- Simultaneous events:
  - If the winner drops req on the same edge the timeout condition is met, it is a normal release and timeout stays 0.
  - A requester that was force-released and keeps req high re-arbitrates with lowest priority, because ptr has already advanced past it.
- Sole requester: if no other req is pending, the grant is held indefinitely even beyond MAX_HOLD.
- Requests that change while in GRANT have no effect until the next arbitration in IDLE.
- Invariants: grant is always 0000 or one-hot. grant_idx == encode(grant). grant_valid == |grant.

Test Plan:
- Reset mid-grant: req=0001, grant=0001. Assert rst asynchronously between edges -> grant=0000, grant_idx=0, grant_valid=0 immediately. After rst is deasserted with req=0100, the next edge gives grant=0100, grant_idx=2.
- Single requester: req=0010 from cycle 0 -> after edge 1, grant=0010, grant_idx=1, grant_valid=1. Drop req -> grant=0000 after the next edge, then one idle cycle.
- Round-robin rotation: req=1111 held, each winner drops req for one cycle after 3 cycles of grant -> grant order 0001, 0010, 0100, 1000, 0001, with one dead cycle between each.
- Priority wrap: ptr=3 (after granting requester 2), req=1001 -> grant=1000 (idx 3); next arbitration with req=1001 -> grant=0001 (idx 0).
- Timeout, MAX_HOLD=4: requester 0 holds req, req=0011 -> grant=0001 for exactly 4 cycles, then timeout=1 for one cycle with grant=0000, then grant=0010. Repeat with req=0001 only -> no timeout, grant held for 20+ cycles.
- Simultaneous drop and timeout: at hold_cnt==MAX_HOLD-1, the winner drops req while other requests are pending -> release with timeout=0.

Source files
------------

// File: rtl/rr_encoder_arbiter.sv
// rr_encoder_arbiter
//   Round-robin arbiter sharing one downstream resource among N_REQ (=4)
//   requesters. A winner keeps the grant while it holds its request.
//   Optionally, the grant is force-released after MAX_HOLD cycles if
//   other requesters are waiting. Every release passes through IDLE for
//   at least one cycle, so two grants never follow each other directly.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req          level-sensitive request lines, bit i = requester i
//   grant        registered one-hot grant, 0 when idle
//   grant_idx    binary index of the granted requester, 0 when idle
//   grant_valid  high while any grant bit is set
//   timeout      one-cycle pulse in the cycle that follows a forced release
//   hold_cnt     cycles the current grant has been held, saturating (debug)
module rr_encoder_arbiter #(
    parameter int N_REQ    = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout,
    output logic [7:0]       hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    // hold_cnt value in the last grant cycle allowed while others wait
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam bit         TO_EN     = (MAX_HOLD != 0);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic [7:0]       hold_nxt;

    // Rotating priority search: first set request at ptr, ptr+1, ... (mod N)
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    logic owner_req;   // current winner still requesting
    logic others_wait; // some other requester is pending
    logic hold_expired;

    assign owner_req    = |(req & grant);
    assign others_wait  = |(req & ~grant);
    assign hold_expired = TO_EN && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        grant_nxt   = grant;
        idx_nxt     = grant_idx;
        valid_nxt   = grant_valid;
        timeout_nxt = 1'b0;
        hold_nxt    = hold_cnt;
        case (state)
            IDLE: begin
                grant_nxt = '0;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
                hold_nxt  = '0;
                if (found) begin
                    grant_nxt = N_REQ'(1) << win;
                    idx_nxt   = win;
                    valid_nxt = 1'b1;
                    ptr_nxt   = win + IDX_W'(1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A drop by the winner takes precedence over the timeout, so
                // a simultaneous drop never reports a forced release.
                if (!owner_req || (hold_expired && others_wait)) begin
                    grant_nxt   = '0;
                    idx_nxt     = '0;
                    valid_nxt   = 1'b0;
                    hold_nxt    = '0;
                    timeout_nxt = owner_req;
                    state_nxt   = IDLE;
                end else if (hold_cnt != 8'hFF) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant       <= grant_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
            timeout     <= timeout_nxt;
            hold_cnt    <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Self-checking bench for rr_encoder_arbiter (MAX_HOLD = 4).
// A reference model tracks the current owner as an integer (-1 = idle),
// a hold count and the rotating priority pointer; a compare process checks
// every output at each negedge. Directed segments pin literal values.
module tb_rr_encoder_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    logic [7:0] hold_cnt;

    int tests = 0;
    int fails = 0;

    rr_encoder_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_idx(grant_idx),
        .grant_valid(grant_valid), .timeout(timeout), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_own  = -1;  // granted requester, -1 when idle
    int m_hold = 0;
    int m_ptr  = 0;
    bit m_to   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_own = -1; m_hold = 0; m_ptr = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_own < 0) begin
                int pick;
                pick = -1;
                for (int k = 0; k < 4; k++)
                    if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
                if (pick >= 0) begin
                    m_own = pick; m_hold = 0; m_ptr = (pick + 1) % 4;
                end
            end else if (!req[m_own]) begin
                m_own = -1; m_hold = 0;
            end else if (MH > 0 && m_hold == MH - 1 && (req & ~(4'b1 << m_own)) != 0) begin
                m_own = -1; m_hold = 0; m_to = 1'b1;
            end else begin
                m_hold = (m_hold >= 255) ? 255 : m_hold + 1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("grant",       int'(grant),       m_own < 0 ? 0 : (1 << m_own));
            chk("grant_idx",   int'(grant_idx),   m_own < 0 ? 0 : m_own);
            chk("grant_valid", int'(grant_valid), m_own >= 0 ? 1 : 0);
            chk("timeout",     int'(timeout),     int'(m_to));
            chk("hold_cnt",    int'(hold_cnt),    m_hold);
            chk("onehot_inv",  int'($countones(grant) <= 1), 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [3:0] g, input int idx, input bit to);
        chk({name, "_grant"},   int'(grant),       int'(g));
        chk({name, "_idx"},     int'(grant_idx),   idx);
        chk({name, "_valid"},   int'(grant_valid), int'(|g));
        chk({name, "_timeout"}, int'(timeout),     int'(to));
    endtask

    initial begin
        // reset state
        step(); step();
        lit("reset", 4'b0000, 0, 0);
        chk("reset_hold", int'(hold_cnt), 0);
        rst = 1'b0;

        // reset mid-grant, then grant to requester 2
        req = 4'b0001; step();
        lit("pre_rst", 4'b0001, 0, 0);
        #2 rst = 1'b1;
        #1 lit("async_rst", 4'b0000, 0, 0);
        req = 4'b0100;
        #1 rst = 1'b0;
        step();
        lit("post_rst", 4'b0100, 2, 0);
        req = 4'b0000; step(); step();

        // priority wrap: ptr=3, req=1001 -> 3, then forced release -> 0
        req = 4'b1001; step();
        lit("wrap3", 4'b1000, 3, 0);
        step(); step(); step();
        chk("wrap_hold3", int'(hold_cnt), 3);
        step();
        lit("wrap_to", 4'b0000, 0, 1);
        step();
        lit("wrap0", 4'b0001, 0, 0);
        req = 4'b0000; step(); step();

        // single requester, ptr=1
        req = 4'b0010; step();
        lit("single", 4'b0010, 1, 0);
        step();
        req = 4'b0000; step();
        lit("single_rel", 4'b0000, 0, 0);
        step();
        lit("single_idle", 4'b0000, 0, 0);

        // timeout with requester 0 holding, ptr=2 -> winner 0
        req = 4'b0011; step();
        lit("to_g0", 4'b0001, 0, 0);
        step(); step(); step();
        lit("to_g3", 4'b0001, 0, 0);
        step();
        lit("to_pulse", 4'b0000, 0, 1);
        step();
        lit("to_next", 4'b0010, 1, 0);
        req = 4'b0000; step(); step();

        // sole requester, ptr=2: held well past MAX_HOLD, hold_cnt saturates
        req = 4'b0001; step();
        lit("sole0", 4'b0001, 0, 0);
        for (int i = 0; i < 300; i++) step();
        lit("sole_long", 4'b0001, 0, 0);
        chk("sole_sat", int'(hold_cnt), 255);
        req = 4'b0000; step(); step();

        // simultaneous drop and timeout, ptr=1 -> winner 1
        req = 4'b0011; step();
        lit("sim_g", 4'b0010, 1, 0);
        step(); step(); step();
        chk("sim_hold3", int'(hold_cnt), 3);
        req = 4'b0001; step();
        lit("sim_rel", 4'b0000, 0, 0);
        step();
        lit("sim_next", 4'b0001, 0, 0);
        req = 4'b0000; step(); step();

        // round-robin rotation from ptr=0
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        req = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            step();
            lit("rr_win", 4'b0001 << (w % 4), w % 4, 0);
            step(); step();
            req = 4'b1111 & ~(4'b0001 << (w % 4));
            step();
            lit("rr_dead", 4'b0000, 0, 0);
            req = 4'b1111;
        end
        req = 4'b0000; step(); step();

        // randomized traffic with occasional async reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 400) == 0) begin
                #2 rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
